// File: rtl/sum_accumulator.sv
// Accumulates COUNT unsigned operands into a WIDTH-bit sum with a sticky carry flag,
// then holds the result on a valid/ready output until the consumer takes it.
module sum_accumulator #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry
);

    localparam int unsigned CNT_W = (COUNT > 2) ? $clog2(COUNT) : 1;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   acc_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [WIDTH:0]     sum_d;
    logic               last_d;

    // One extra bit captures the carry-out of the pending addition.
    assign sum_d  = {1'b0, acc_q} + {1'b0, in_data};
    assign last_d = (cnt_q == CNT_W'(COUNT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACC;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (clr) begin
            state_q     <= ACC;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (in_valid) begin
                        acc_q   <= sum_d[WIDTH-1:0];
                        carry_q <= carry_q | sum_d[WIDTH];
                        if (last_d) begin
                            // Counter parks at zero; the result is now held in acc_q/carry_q.
                            cnt_q       <= '0;
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        acc_q       <= '0;
                        carry_q     <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= ACC;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ACC;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;
    assign out_carry = carry_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator: directed scenarios plus a randomized run
// against a reference model that tracks the true integer sum of accepted operands.
module tb_sum_accumulator;

    localparam int unsigned W = 16;
    localparam int unsigned N = 4;

    logic         clk;
    logic         rst;
    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;

    int n_cmp;
    int n_err;

    sum_accumulator #(.WIDTH(W), .COUNT(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand for exactly one edge.
    task automatic push(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = $urandom();
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #3;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0 || out_carry !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: valid=%b ready=%b sum=%0d carry=%b required 0 1 0 0",
                     out_valid, in_ready, out_sum, out_carry);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int vcycles;
        out_ready = 1'b1;
        push(16'd1024); push(16'd1); push(16'd0); push(16'd0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_sum !== 16'd1025 || out_carry !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL basic_result: valid=%b sum=%0d carry=%b ready=%b required 1 1025 0 0",
                     out_valid, out_sum, out_carry, in_ready);
        end
        vcycles = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_valid === 1'b1) vcycles++;
        end
        n_cmp++;
        if (vcycles != 1 || in_ready !== 1'b1 || out_sum !== '0) begin
            n_err++;
            $display("FAIL basic_one_cycle: valid_cycles=%0d ready=%b sum=%0d required 1 1 0",
                     vcycles, in_ready, out_sum);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        out_ready = 1'b0;
        push(16'd65534); push(16'd1);
        n_cmp++;
        if (out_sum !== 16'd65535 || out_carry !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_no_carry: sum=%0d carry=%b required 65535 0", out_sum, out_carry);
        end
        push(16'd1); push(16'd0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_sum !== 16'd0 || out_carry !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_carry: valid=%b sum=%0d carry=%b required 1 0 1", out_valid, out_sum, out_carry);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        push(16'd1024); push(16'd1024); push(16'd0); push(16'd0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_sum !== 16'd2048 || out_carry !== 1'b0) begin
            n_err++;
            $display("FAIL carry_cleared: valid=%b sum=%0d carry=%b required 1 2048 0", out_valid, out_sum, out_carry);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int bad;
        out_ready = 1'b0;
        push(16'd1); push(16'd2); push(16'd3); push(16'd4);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom();
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 16'd10 || out_carry !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL hold_stable: bad_cycles=%0d required 0 (last sum=%0d ready=%b)", bad, out_sum, in_ready);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== '0) begin
            n_err++;
            $display("FAIL hold_transfer: valid=%b ready=%b sum=%0d required 0 1 0", out_valid, in_ready, out_sum);
        end
        push(16'd1); push(16'd1); push(16'd1); push(16'd1);
        n_cmp++;
        if (out_valid !== 1'b1 || out_sum !== 16'd4) begin
            n_err++;
            $display("FAIL hold_ignored_inputs: valid=%b sum=%0d required 1 4", out_valid, out_sum);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_gaps();
        int bad;
        int running;
        logic [W-1:0] ops [4];
        ops[0] = 16'd10; ops[1] = 16'd20; ops[2] = 16'd30; ops[3] = 16'd40;
        bad = 0; running = 0;
        for (int i = 0; i < 4; i++) begin
            push(ops[i]);
            running += int'(ops[i]);
            if (out_sum !== W'(running)) bad++;
            if (i < 3) begin
                in_data = $urandom();
                tick();
                if (out_sum !== W'(running) || out_valid !== 1'b0) bad++;
            end
        end
        n_cmp++;
        if (bad != 0 || out_valid !== 1'b1 || out_sum !== 16'd100) begin
            n_err++;
            $display("FAIL gaps: bad=%0d valid=%b sum=%0d required 0 1 100", bad, out_valid, out_sum);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_clr();
        push(16'd5); push(16'd7);
        clr = 1'b1; in_valid = 1'b1; in_data = 16'd9;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (out_sum !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL clr_abort: sum=%0d valid=%b ready=%b required 0 0 1", out_sum, out_valid, in_ready);
        end
        push(16'd1); push(16'd1); push(16'd1);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL clr_count_reset: valid=%b required 0 after 3 operands", out_valid);
        end
        push(16'd1);
        n_cmp++;
        if (out_valid !== 1'b1 || out_sum !== 16'd4) begin
            n_err++;
            $display("FAIL clr_result: valid=%b sum=%0d required 1 4", out_valid, out_sum);
        end
        // Clearing a held result discards it.
        clr = 1'b1; tick(); clr = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || out_sum !== '0) begin
            n_err++;
            $display("FAIL clr_in_hold: valid=%b sum=%0d required 0 0", out_valid, out_sum);
        end
    endtask

    task automatic test_async_reset();
        push(16'd100); push(16'd200); push(16'd300);
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_sum !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_carry !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst_acc: sum=%0d valid=%b ready=%b carry=%b required 0 0 1 0",
                     out_sum, out_valid, in_ready, out_carry);
        end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        push(16'd65535); push(16'd3); push(16'd3); push(16'd3);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL async_rst_prehold: valid=%b required 1", out_valid);
        end
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_sum !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_carry !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst_hold: sum=%0d valid=%b ready=%b carry=%b required 0 0 1 0",
                     out_sum, out_valid, in_ready, out_carry);
        end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        push(16'd2); push(16'd2); push(16'd2); push(16'd2);
        n_cmp++;
        if (out_valid !== 1'b1 || out_sum !== 16'd8 || out_carry !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst_after: valid=%b sum=%0d carry=%b required 1 8 0", out_valid, out_sum, out_carry);
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    // Model: true integer total of accepted operands; sum is total mod 2^W and the
    // sticky carry is set exactly when that total has reached 2^W.
    task automatic test_random();
        longint unsigned total;
        int              taken;
        bit              holding;
        bit              v, r, c;
        logic [W-1:0]    d;
        int              bad;
        logic [W-1:0]    exp_sum;
        logic            exp_carry;
        total = 0; taken = 0; holding = 1'b0; bad = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 40) == 0);
            d = ($urandom_range(0, 3) == 0) ? W'($urandom_range(65000, 65535)) : W'($urandom());
            in_valid = v; out_ready = r; clr = c; in_data = d;
            tick();
            if (c) begin
                total = 0; taken = 0; holding = 1'b0;
            end else if (holding) begin
                if (r) begin
                    total = 0; taken = 0; holding = 1'b0;
                end
            end else if (v) begin
                total += longint'(d);
                taken++;
                if (taken == N) holding = 1'b1;
            end
            exp_sum   = W'(total % 65536);
            exp_carry = (total >= 65536);
            n_cmp++;
            if (out_valid !== holding || in_ready !== !holding || out_sum !== exp_sum || out_carry !== exp_carry) begin
                n_err++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random_cycle%0d: valid=%b ready=%b sum=%0d carry=%b required %b %b %0d %b",
                             cyc, out_valid, in_ready, out_sum, out_carry, holding, !holding, exp_sum, exp_carry);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_gaps();
        test_clr();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter WIDTH, default 16, data width of operands and sum; matches the downstream 16-bit adder datapath.
REQ-002 Parameter COUNT, default 4, number of operands summed per result; legal range 2..256.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 clr  input  1  synchronous abort of the current accumulation.
REQ-006 in_valid  input  1  in_data carries an operand this cycle.
REQ-007 in_ready  output  1  block accepts an operand this cycle.
REQ-008 in_data  input  WIDTH  unsigned operand.
REQ-009 out_valid  output  1  out_sum/out_carry hold a completed result.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 out_sum  output  WIDTH  sum of COUNT operands, modulo 2^WIDTH.
REQ-012 out_carry  output  1  sticky flag: at least one addition in this result carried out of bit WIDTH-1.

Function
REQ-013 The FSM SHALL have exactly two states: ACC (collecting operands) and HOLD (presenting a result).
REQ-014 In ACC, in_ready SHALL be 1 and out_valid SHALL be 0; in HOLD, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-015 An operand SHALL be accepted only on a rising edge where in_valid=1 and in_ready=1; in_data is ignored otherwise.
REQ-016 On acceptance: acc <= (acc + in_data) mod 2^WIDTH; carry <= carry | carry-out of that addition; cnt <= cnt + 1.
REQ-017 Wrap-around example: 65535 + 1 SHALL yield acc=0 with carry=1; 65534 + 1 SHALL yield 65535 with carry unchanged.
REQ-018 When the accepted operand is number COUNT (cnt = COUNT-1 before the edge), the FSM SHALL enter HOLD on that same edge, with out_sum and out_carry already reflecting that operand.
REQ-019 Latency: out_valid SHALL assert in the cycle immediately following the edge that accepted the last operand.
REQ-020 In HOLD, out_sum and out_carry SHALL remain stable until the transfer completes (out_valid=1 and out_ready=1 on a rising edge).
REQ-021 On transfer completion: acc, cnt, and carry SHALL clear to 0, and the FSM SHALL return to ACC.
REQ-022 in_ready is 0 for the whole of HOLD, so a new operand is accepted no earlier than the cycle after the transfer (no bypass).
REQ-023 out_ready asserted while in ACC SHALL have no effect.
REQ-024 clr=1 on a rising edge SHALL clear acc, cnt, and carry, force ACC, and discard any concurrent operand or pending result; clr has priority over every other input.
REQ-025 out_sum SHALL be driven directly from the acc register, and out_carry directly from the carry register; neither output has a combinational path from in_data.
REQ-026 cnt SHALL be ceil(log2(COUNT)) bits wide or wider, and SHALL never exceed COUNT-1 in ACC.

Reset
REQ-027 While rst=1, asynchronously and regardless of clk: state=ACC, acc=0, cnt=0, carry=0, out_valid=0, in_ready=1.
REQ-028 Reset asserted mid-accumulation or during HOLD SHALL discard all partial sums and pending results, and no result from before reset SHALL ever appear.
REQ-029 After rst deasserts, the first rising edge SHALL be able to accept an operand.

Verification
REQ-030 COUNT=4, operands 1024, 1, 0, 0 back-to-back, out_ready=1 -> out_valid for one cycle, 1 cycle after the 4th operand, with out_sum=1025 and out_carry=0.
REQ-031 Operands 65535, 1, 0, 0 -> out_sum=0, out_carry=1; next result from 1024, 1024, 0, 0 -> out_sum=2048, out_carry=0 (sticky flag cleared).
REQ-032 Operands 1, 2, 3, 4 with out_ready held 0 for 5 cycles -> out_sum=10 held stable and in_ready=0 throughout; in_valid pulses during the hold are ignored; the transfer occurs when out_ready rises.
REQ-033 in_valid toggled every other cycle (gaps) with operands 10, 20, 30, 40 -> out_sum=100; the gaps neither advance cnt nor change acc.
REQ-034 After 2 operands (5, 7), pulse clr together with in_valid=1 carrying 9, then send 1, 1, 1, 1 -> out_sum=4 (5, 7, and 9 discarded).
REQ-035 Assert rst asynchronously between edges after 3 operands and again during HOLD -> outputs go to reset values immediately, and the next 4 operands 2, 2, 2, 2 give out_sum=8.
